pipe_stage_skid: RTL
====================

# pipe_stage_skid

Parametrised, handshaked pipeline register that replaces the fixed stall/enable stage registers between core pipeline stages (IF/ID and later). It carries an opaque DATA_W-bit payload (PC, instruction, BTB prediction bits, etc.) with valid/ready flow control. A two-entry skid buffer keeps every ready path registered, and a synchronous flush inserts a configurable bubble pattern (e.g. a NOP instruction) for branch mispredicts and interrupt entry.

## Interface
- DATA_W, 32: payload width in bits; legal range 1..1024.
- BUBBLE_VAL, {DATA_W{1'b0}}: payload presented on o_data whenever the stage is empty. The instantiator passes a NOP encoding here, e.g. instruction field = 32'h00000013.
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst_n  input  1  reset, synchronous, active-low.
- i_flush  input  1  synchronous kill of all held entries and of the same-cycle input.
- i_valid  input  1  upstream offers i_data.
- o_ready  output  1  stage can accept; driven from a register only.
- i_data  input  DATA_W  upstream payload.
- o_valid  output  1  o_data holds a live entry.
- i_ready  input  1  downstream accepts o_data this cycle.
- o_data  output  DATA_W  head payload, or BUBBLE_VAL when empty.
- o_count  output  2  number of held entries: 0, 1 or 2.

## Operation
- Storage:
  - main register, which drives o_data;
  - skid register;
  - a state of EMPTY, ONE or FULL.
- o_count is 0, 1 or 2 for EMPTY, ONE or FULL.
- Handshake terms:
  - accept = i_valid & o_ready.
  - fire = o_valid & i_ready.
- Output decode:
  - o_valid = (state != EMPTY).
  - o_ready = (state != FULL).
  - Both are decoded from the state register only, so there is no combinational path from i_valid or i_ready to any output.
- Priority each edge: reset, then flush, then the normal transitions below.
- Reset (i_rst_n=0):
  - state <= EMPTY.
  - main <= BUBBLE_VAL; skid <= BUBBLE_VAL.
  - Outputs after the edge: o_valid=0, o_ready=1, o_count=0, o_data=BUBBLE_VAL.
- Flush (i_flush=1, i_rst_n=1):
  - Same register updates as reset.
  - Any accept in that cycle is discarded.
  - Upstream still sees o_ready as it was, so its handshake completes and the item is dropped.
  - A fire in the same cycle still completes downstream; the item is not recalled.
- Transitions in EMPTY:
  - accept: main <= i_data; go to ONE.
  - otherwise: hold.
- Transitions in ONE:
  - accept & !fire: skid <= i_data; go to FULL.
  - !accept & fire: main <= BUBBLE_VAL; go to EMPTY.
  - accept & fire: main <= i_data; stay in ONE.
  - neither: hold.
- Transitions in FULL (no accept is possible because o_ready=0):
  - fire: main <= skid; skid <= BUBBLE_VAL; go to ONE.
  - otherwise: hold.
- Ordering: entries leave strictly in accept order. No entry is dropped or duplicated except by flush.
- o_data is stable while o_valid=1 and i_ready=0.
- i_valid or i_data changing while o_ready=0 has no effect.

## Timing
- Latency: an item accepted at edge N appears on o_data with o_valid=1 after edge N, provided the stage was EMPTY, or was ONE and fired at edge N.
- Throughput: one item per cycle sustained while i_ready=1.
- Backpressure: i_ready=0 for one cycle while streaming moves the stage ONE -> FULL and drops o_ready to 0 one cycle later. This is the skid absorption.
- Recovery: the first fire in FULL returns o_ready to 1 after that edge.
- Flush recovery: o_ready=1 and o_valid=0 on the cycle after the flush edge. A new accept is possible in that same cycle.
- Reset mid-stream behaves identically to flush, and takes precedence when i_flush=1 in the same cycle.

## Test plan
- Reset with DATA_W=64 and BUBBLE_VAL=64'h0000_0000_0000_0013. Hold i_rst_n=0 for 2 cycles with i_valid=1.
  - Required: o_valid=0, o_ready=1, o_count=0 and o_data=64'h13 after the release edge.
- Streaming: i_ready=1 constant; send 0xA0..0xA7 back-to-back.
  - Required: each value appears exactly one cycle after its accept, in order, with o_count=1 throughout and o_ready=1 throughout.
- Skid: stream 0x10, 0x11, 0x12, 0x13 and drop i_ready for 3 cycles after 0x10 is presented.
  - Required: o_count reaches 2 and o_ready falls to 0.
  - Required: o_data holds 0x10 steadily.
  - Required: after i_ready returns, the outputs are 0x10, 0x11, 0x12, 0x13 in order with no loss.
- Flush while FULL (entries 0x20 and 0x21), asserted with i_valid=1 carrying 0x22.
  - Required next cycle: o_valid=0, o_count=0, o_data=BUBBLE_VAL.
  - Required: 0x22 is never emitted, and the next accepted value 0x23 is output correctly.
- Random: random i_valid, i_ready, i_flush (5%) and i_rst_n (1%) over 10k cycles, checked against a 2-deep queue scoreboard.
  - Required: no reorder, loss or duplication between flushes.
  - Required: no change to o_data while o_valid=1 and i_ready=0.
  - Required: o_ready == (o_count != 2) every cycle.

Source files
------------

// File: rtl/pipe_stage_skid_if.sv
// Handshake bundle for pipe_stage_skid: upstream valid/ready/data,
// downstream valid/ready/data, flush and occupancy.
interface pipe_stage_skid_if #(
  parameter int DATA_W = 32
);
  logic              i_flush;
  logic              i_valid;
  logic              o_ready;
  logic [DATA_W-1:0] i_data;
  logic              o_valid;
  logic              i_ready;
  logic [DATA_W-1:0] o_data;
  logic [1:0]        o_count;

  modport slave (
    input  i_flush,
    input  i_valid,
    input  i_data,
    input  i_ready,
    output o_ready,
    output o_valid,
    output o_data,
    output o_count
  );

  modport master (
    output i_flush,
    output i_valid,
    output i_data,
    output i_ready,
    input  o_ready,
    input  o_valid,
    input  o_data,
    input  o_count
  );
endinterface

// File: rtl/pipe_stage_skid.sv
// Two-entry skid pipeline register with registered ready/valid and
// synchronous flush that refills the stage with a bubble payload.
module pipe_stage_skid #(
  parameter int                DATA_W     = 32,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = '0
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  pipe_stage_skid_if.slave      bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;

  logic accept;
  logic fire;

  // Handshake outputs come from the state register only
  assign bus.o_valid = (state_q != EMPTY);
  assign bus.o_ready = (state_q != FULL);
  assign bus.o_count = state_q;
  assign bus.o_data  = main_q;

  assign accept = bus.i_valid & bus.o_ready;
  assign fire   = bus.o_valid & bus.i_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (bus.i_flush) begin
      state_d = EMPTY;
      main_d  = BUBBLE_VAL;
      skid_d  = BUBBLE_VAL;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            main_d  = bus.i_data;
            state_d = ONE;
          end
        end
        ONE: begin
          unique case (1'b1)
            accept & ~fire: begin
              skid_d  = bus.i_data;
              state_d = FULL;
            end
            ~accept & fire: begin
              main_d  = BUBBLE_VAL;
              state_d = EMPTY;
            end
            accept & fire: begin
              main_d  = bus.i_data;
            end
            default: ;
          endcase
        end
        FULL: begin
          if (fire) begin
            main_d  = skid_q;
            skid_d  = BUBBLE_VAL;
            state_d = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= EMPTY;
      main_q  <= BUBBLE_VAL;
      skid_q  <= BUBBLE_VAL;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule
